phy_rx_sync_ctrl: RTL
=====================

Name: phy_rx_sync_ctrl

Overview:
Receive-side sync controller for the two-lane serial PHY. It deserializes lanes in_0 and in_1 at clk_8f and finds each lane's byte boundary by hunting for the comma 0xBC. After COMMA_NUM aligned commas it declares the lane synchronized, then presents non-comma bytes with a valid strobe. It sits between the serial pins and the lane unstriping logic, and gates that logic through the active output.

Parameters:
COMMA_NUM, 4, consecutive aligned commas required to enter SYNC (range 1..15)
MAX_RUN, 16, max consecutive non-comma bytes tolerated in SYNC before loss of sync (range 1..255)

Ports:
clk_8f  in  1  bit clock; all logic on posedge
reset  in  1  synchronous, active-high reset
enable  in  1  receive enable; low forces both lanes to HUNT
in_0  in  1  lane 0 serial bit, MSB first
in_1  in  1  lane 1 serial bit, MSB first
data_out_0  out  8  lane 0 received byte
valid_out_0  out  1  lane 0 byte valid, one-cycle pulse
data_out_1  out  8  lane 1 received byte
valid_out_1  out  1  lane 1 byte valid, one-cycle pulse
sync_0  out  1  lane 0 in SYNC
sync_1  out  1  lane 1 in SYNC
active  out  1  sync_0 & sync_1, registered

Behaviour:
- Clock and reset: one clock, clk_8f. Reset is synchronous and active-high. Reset values: all outputs 0, shift registers 0, both lanes in HUNT, all counters 0.
- Per lane, every clock while enable=1: shift register sr <= {sr[6:0], in_x}.
- HUNT:
  - Compare {sr[6:0], in_x} to 0xBC every cycle.
  - On a match: go to LOCK, phase counter <= 0, comma count <= 1.
- LOCK:
  - 3-bit phase counter increments every clock. A byte boundary is the cycle where phase==7, using the same next-window compare.
  - Boundary byte == 0xBC: comma count +1. If the count reaches COMMA_NUM, go to SYNC.
  - Boundary byte != 0xBC: return to HUNT, comma count <= 0.
  - If COMMA_NUM==1, the HUNT match goes straight to SYNC.
- SYNC:
  - At each boundary, byte == 0xBC is an idle: valid_out_x=0, run counter <= 0.
  - Any other byte: data_out_x <= byte, valid_out_x=1 for one cycle, run counter +1.
  - If the run counter would exceed MAX_RUN: go to HUNT. That byte is still delivered as valid.
- Output timing:
  - data_out_x and valid_out_x update on the clock edge that samples the 8th bit of the byte.
  - data_out_x holds its last value between pulses.
  - valid_out_x is never high in HUNT or LOCK.
- sync_x is 1 exactly while the lane is in SYNC. active follows one cycle after both sync_x are 1, and drops one cycle after either falls.
- The two lanes are fully independent. Simultaneous lane events are each handled per lane; there is no inter-lane skew requirement.
- enable=0: both lanes go to HUNT next clock. valid_out_x, sync_x and active go to 0; counters clear; the shift registers are not shifted. Same for reset mid-frame.
- Re-entering after loss requires a full HUNT -> LOCK -> SYNC sequence.

Optional Feature:
- Macro: PHY_RX_SYNC_ERR_CNT_EN.
- When defined: adds output ports err_cnt_0[7:0] and err_cnt_1[7:0].
  - Each counter increments on every LOCK->HUNT or SYNC->HUNT transition of its lane.
  - Transitions caused by enable=0 are not counted.
  - The counters saturate at 0xFF and are cleared by reset.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package phy_rx_pkg holds:
  - COMMA = 8'hBC
  - lane state encoding: HUNT=2'd0, LOCK=2'd1, SYNC=2'd2
- Sub-module phy_rx_lane_sync implements one lane (shift register, phase counter, comma and run counters, FSM, optional error counter).
- It is instantiated twice. The top level adds only the active register.

Test Plan:
1. reset=1 for 8 clocks with enable=1 and random bits -> all outputs 0, both lanes in HUNT.
2. Four 0xBC bytes on both lanes, then 0xFF on lane 0 and 0x00 on lane 1 -> sync_0/sync_1=1 at the 4th comma's last bit, active one cycle later; then valid_out_0=1 with data 0xFF and valid_out_1=1 with data 0x00, one pulse per 8 clocks.
3. While in SYNC, send 0xEE, 0xEE, 0xDD, 0xDD, then 0xBC, then 0xAA -> four valid pulses, no pulse for the 0xBC, then 0xAA valid.
4. Three 0xBC followed by 0x12 in LOCK -> lane returns to HUNT and sync stays 0. With PHY_RX_SYNC_ERR_CNT_EN defined, err_cnt increments to 1.
5. In SYNC, send 17 consecutive non-comma bytes (MAX_RUN=16) -> 17 valid pulses, then sync drops and active drops one cycle later.
6. enable=0 mid-byte while in SYNC -> next clock valid/sync/active=0. Re-enable and send four 0xBC offset by 3 bits -> relocks at the new boundary.

Source files
------------

// File: rtl/phy_rx_pkg.sv
// Shared constants and lane state encoding for the two-lane PHY receive sync controller.
package phy_rx_pkg;

  localparam logic [7:0] COMMA = 8'hBC;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LOCK = 2'd1,
    SYNC = 2'd2
  } lane_state_e;

  function automatic logic is_comma(input logic [7:0] byte_v);
    return (byte_v == COMMA);
  endfunction

endpackage

// File: rtl/phy_rx_lane_sync.sv
// One receive lane: deserializer, comma hunt/lock, byte delivery and loss-of-sync detection.
// Optional macro PHY_RX_SYNC_ERR_CNT_EN adds a saturating loss-of-lock counter.
module phy_rx_lane_sync
  import phy_rx_pkg::*;
#(
  parameter int COMMA_NUM = 4,
  parameter int MAX_RUN   = 16
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       enable,
  input  logic       in_bit,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       sync
`ifdef PHY_RX_SYNC_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [3:0] COMMA_NUM_C = 4'(COMMA_NUM);
  localparam logic [8:0] MAX_RUN_C   = 9'(MAX_RUN);

  // Only the last seven bits are kept; the incoming bit completes the window.
  logic [6:0]  sr_r, sr_n;
  lane_state_e state_r, state_n;
  logic [2:0]  phase_r, phase_n;
  logic [3:0]  comma_cnt_r, comma_n;
  logic [7:0]  run_cnt_r, run_n;
  logic [7:0]  data_r, data_n;
  logic        valid_r, valid_n;
  logic        sync_r;
  logic [7:0]  window_s;
  logic        comma_s;
  logic        boundary_s;
  logic [3:0]  comma_inc_s;
  logic [8:0]  run_inc_s;
  logic        to_hunt_s;

  // State and datapath registers.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      sr_r        <= 7'd0;
      state_r     <= HUNT;
      phase_r     <= 3'd0;
      comma_cnt_r <= 4'd0;
      run_cnt_r   <= 8'd0;
      data_r      <= 8'd0;
      valid_r     <= 1'b0;
      sync_r      <= 1'b0;
    end else begin
      sr_r        <= sr_n;
      state_r     <= state_n;
      phase_r     <= phase_n;
      comma_cnt_r <= comma_n;
      run_cnt_r   <= run_n;
      data_r      <= data_n;
      valid_r     <= valid_n;
      sync_r      <= (state_n == SYNC);
    end
  end

  // Next-state and output decode.
  always_comb begin
    window_s    = {sr_r, in_bit};
    comma_s     = is_comma(window_s);
    boundary_s  = (phase_r == 3'd7);
    comma_inc_s = comma_cnt_r + 4'd1;
    run_inc_s   = {1'b0, run_cnt_r} + 9'd1;
    sr_n        = sr_r;
    state_n     = state_r;
    phase_n     = phase_r + 3'd1;
    comma_n     = comma_cnt_r;
    run_n       = run_cnt_r;
    data_n      = data_r;
    valid_n     = 1'b0;
    to_hunt_s   = 1'b0;
    if (!enable) begin
      state_n = HUNT;
      phase_n = 3'd0;
      comma_n = 4'd0;
      run_n   = 8'd0;
    end else begin
      sr_n = window_s[6:0];
      case (state_r)
        HUNT: begin
          phase_n = 3'd0;
          if (comma_s) begin
            comma_n = 4'd1;
            run_n   = 8'd0;
            if (COMMA_NUM == 1) begin
              state_n = SYNC;
            end else begin
              state_n = LOCK;
            end
          end else begin
            comma_n = 4'd0;
          end
        end
        LOCK: begin
          if (boundary_s && comma_s) begin
            comma_n = comma_inc_s;
            if (comma_inc_s == COMMA_NUM_C) begin
              state_n = SYNC;
            end else begin
              state_n = LOCK;
            end
          end else if (boundary_s) begin
            state_n   = HUNT;
            phase_n   = 3'd0;
            comma_n   = 4'd0;
            to_hunt_s = 1'b1;
          end else begin
            state_n = LOCK;
          end
        end
        SYNC: begin
          if (boundary_s && comma_s) begin
            run_n = 8'd0;
          end else if (boundary_s) begin
            // The byte that overflows the run is still delivered.
            data_n  = window_s;
            valid_n = 1'b1;
            if (run_inc_s > MAX_RUN_C) begin
              state_n   = HUNT;
              phase_n   = 3'd0;
              comma_n   = 4'd0;
              run_n     = 8'd0;
              to_hunt_s = 1'b1;
            end else begin
              run_n = run_inc_s[7:0];
            end
          end else begin
            state_n = SYNC;
          end
        end
        default: begin
          state_n = HUNT;
          phase_n = 3'd0;
          comma_n = 4'd0;
          run_n   = 8'd0;
        end
      endcase
    end
  end

  assign data_out  = data_r;
  assign valid_out = valid_r;
  assign sync      = sync_r;

`ifdef PHY_RX_SYNC_ERR_CNT_EN
  logic [7:0] err_cnt_r;

  // Saturating count of lock losses; disable-driven drops never set to_hunt_s.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      err_cnt_r <= 8'd0;
    end else if (to_hunt_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// Two-lane receive sync controller; active gates the downstream unstriping logic.
// Optional macro PHY_RX_SYNC_ERR_CNT_EN exposes per-lane error counters.
module phy_rx_sync_ctrl
  import phy_rx_pkg::*;
#(
  parameter int COMMA_NUM = 4,
  parameter int MAX_RUN   = 16
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       enable,
  input  logic       in_0,
  input  logic       in_1,
  output logic [7:0] data_out_0,
  output logic       valid_out_0,
  output logic [7:0] data_out_1,
  output logic       valid_out_1,
  output logic       sync_0,
  output logic       sync_1,
  output logic       active
`ifdef PHY_RX_SYNC_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt_0,
  output logic [7:0] err_cnt_1
`endif
);

  logic active_r;

  phy_rx_lane_sync #(.COMMA_NUM(COMMA_NUM), .MAX_RUN(MAX_RUN)) u_lane_0 (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .enable    (enable),
    .in_bit    (in_0),
    .data_out  (data_out_0),
    .valid_out (valid_out_0),
    .sync      (sync_0)
`ifdef PHY_RX_SYNC_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt_0)
`endif
  );

  phy_rx_lane_sync #(.COMMA_NUM(COMMA_NUM), .MAX_RUN(MAX_RUN)) u_lane_1 (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .enable    (enable),
    .in_bit    (in_1),
    .data_out  (data_out_1),
    .valid_out (valid_out_1),
    .sync      (sync_1)
`ifdef PHY_RX_SYNC_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt_1)
`endif
  );

  // Both-lanes-synchronized flag, dropped immediately when receive is disabled.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      active_r <= 1'b0;
    end else begin
      active_r <= enable & sync_0 & sync_1;
    end
  end

  assign active = active_r;

endmodule
